trng_burst_sequencer: RTL and testbench

//  Command-driven scheduler between the RG-based TRNG core and the UART interface, in the clk_50 domain.

---
 rtl/trng_pkg.sv | 36 +++
 rtl/trng_word_serializer.sv | 83 ++++++++
 rtl/trng_burst_sequencer.sv | 163 ++++++++++++++++
 tb/tb_trng_burst_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// ----------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the TRNG burst sequencer slice:
//   - top-level FSM state encoding (state_t)
//   - serializer handshake phase encoding (ser_phase_t)
//   - default host command bytes
//   - TRNG word geometry (32-bit words streamed as 4 bytes)
// ----------------------------------------------------------------------------
package trng_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    localparam logic [7:0] CMD_SINGLE_BYTE = 8'h52;  // 'R'
    localparam logic [7:0] CMD_BURST_BYTE  = 8'h42;  // 'B'
    localparam logic [7:0] CMD_STOP_BYTE   = 8'h53;  // 'S'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CNT,
        ST_ARM,
        ST_SETTLE,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_DONE,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SEND,
        PH_WAIT
    } ser_phase_t;

endpackage

// File: rtl/trng_word_serializer.sv
// ----------------------------------------------------------------------------
// trng_word_serializer
// Captures one TRNG word on start and streams it to the UART transmitter as
// BYTES_PER_WORD bytes, MSB first. Each byte is offered with a single-cycle
// tx_dv strobe once the transmitter is idle, then the serializer waits for the
// transmitter's done strobe before offering the next byte.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      1-cycle request: capture word and begin sending
//   word       WORD_W-bit sample to send
//   tx_active  transmitter busy serialising
//   tx_done    1-cycle strobe: current byte has fully shifted out
//   done       1-cycle strobe, combinational: last byte of the word is done
//   tx_dv      1-cycle strobe to the transmitter (registered)
//   tx_byte    byte presented with tx_dv (registered)
// ----------------------------------------------------------------------------
module trng_word_serializer
    import trng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte
);

    ser_phase_t            phase;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [WORD_W-1:0]     shreg;
    logic                  last_byte;

    assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign done      = (phase == PH_WAIT) && tx_done && last_byte;

    // Handshake control; tx_dv defaults low so it can only ever be a
    // single-cycle pulse per byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH_IDLE;
            byte_idx <= '0;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            tx_dv <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        byte_idx <= '0;
                        phase    <= PH_SEND;
                    end
                end
                PH_SEND: begin
                    if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= shreg[WORD_W-1 -: 8];
                        phase   <= PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (tx_done) begin
                        byte_idx <= byte_idx + BYTE_IDX_W'(1);
                        phase    <= last_byte ? PH_IDLE : PH_SEND;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    // Data path: no reset, the word is always loaded before it is used.
    always_ff @(posedge clk) begin
        if (start && (phase == PH_IDLE)) begin
            shreg <= word;
        end else if ((phase == PH_WAIT) && tx_done) begin
            shreg <= {shreg[WORD_W-9:0], 8'h00};
        end
    end

endmodule

// File: rtl/trng_burst_sequencer.sv
// ----------------------------------------------------------------------------
// trng_burst_sequencer
// Command-driven scheduler between the TRNG core and the UART. Decodes host
// command bytes, sequences the TRNG (reset pulse, enable, settle window,
// sample) and streams each 32-bit sample to the UART transmitter MSB first.
// 'R' returns one word, 'B' followed by a count N returns N words (0 = 256),
// 'S' ends a running request after the word currently in flight.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_rx_dv        1-cycle strobe: i_rx_byte is valid
//   i_rx_byte      received command/count byte
//   o_tx_dv        1-cycle strobe to UART TX
//   o_tx_byte      byte to transmit
//   i_tx_active    UART TX busy
//   i_tx_done      1-cycle strobe: byte fully shifted out
//   o_trng_rst     TRNG core reset
//   o_trng_en      TRNG core enable
//   i_trng_data    TRNG output word
//   o_busy         high whenever the FSM is not idle
//   o_words_left   remaining words including the one in flight
// ----------------------------------------------------------------------------
module trng_burst_sequencer
    import trng_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 32,
    parameter int         RST_CYCLES    = 2,
    parameter logic [7:0] CMD_SINGLE    = CMD_SINGLE_BYTE,
    parameter logic [7:0] CMD_BURST     = CMD_BURST_BYTE,
    parameter logic [7:0] CMD_STOP      = CMD_STOP_BYTE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_trng_rst,
    output logic              o_trng_en,
    input  logic [WORD_W-1:0] i_trng_data,
    output logic              o_busy,
    output logic [8:0]        o_words_left
);

    localparam int CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic             stop_pending;
    logic             stop_hit;
    logic             ser_start;
    logic             ser_done;

    assign stop_hit  = i_rx_dv && (i_rx_byte == CMD_STOP);
    assign ser_start = (state == ST_LATCH);

    trng_word_serializer u_serializer (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (ser_start),
        .word      (i_trng_data),
        .tx_active (i_tx_active),
        .tx_done   (i_tx_done),
        .done      (ser_done),
        .tx_dv     (o_tx_dv),
        .tx_byte   (o_tx_byte)
    );

    // Top FSM. TRNG controls and o_busy are registered and updated on the
    // transition into the state that owns them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cyc_cnt      <= '0;
            stop_pending <= 1'b0;
            o_trng_rst   <= 1'b1;
            o_trng_en    <= 1'b0;
            o_busy       <= 1'b0;
            o_words_left <= 9'd0;
        end else begin
            // Stop is remembered from arming onwards; in GET_CNT the byte
            // is a count and in IDLE there is nothing to stop.
            if (stop_hit && (state != ST_IDLE) && (state != ST_GET_CNT)) begin
                stop_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_rx_dv && (i_rx_byte == CMD_SINGLE)) begin
                        o_words_left <= 9'd1;
                        cyc_cnt      <= '0;
                        o_busy       <= 1'b1;
                        state        <= ST_ARM;
                    end else if (i_rx_dv && (i_rx_byte == CMD_BURST)) begin
                        o_busy <= 1'b1;
                        state  <= ST_GET_CNT;
                    end
                end
                ST_GET_CNT: begin
                    if (i_rx_dv) begin
                        o_words_left <= (i_rx_byte == 8'h00) ? 9'd256 : {1'b0, i_rx_byte};
                        cyc_cnt      <= '0;
                        state        <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (cyc_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        cyc_cnt    <= '0;
                        o_trng_rst <= 1'b0;
                        o_trng_en  <= 1'b1;
                        state      <= ST_SETTLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cyc_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cyc_cnt <= '0;
                        state   <= ST_LATCH;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    // Mirrors the serializer: the byte goes out when TX is idle.
                    if (!i_tx_active) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_tx_done) begin
                        state <= ser_done ? ST_NEXT : ST_SEND;
                    end
                end
                ST_NEXT: begin
                    // A finished or stopped request leaves nothing outstanding,
                    // so the counter is cleared rather than left mid-count.
                    if ((o_words_left <= 9'd1) || stop_pending || stop_hit) begin
                        o_words_left <= 9'd0;
                        stop_pending <= 1'b0;
                        o_trng_rst   <= 1'b1;
                        o_trng_en    <= 1'b0;
                        o_busy       <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        o_words_left <= o_words_left - 9'd1;
                        cyc_cnt      <= '0;
                        state        <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trng_burst_sequencer
// Directed bench: constant TRNG word, UART TX model that holds active for
// 20 cycles after each strobe and then pulses done, one task per scenario.
// ----------------------------------------------------------------------------
module tb_trng_burst_sequencer;

    localparam int          SETTLE = 32;
    localparam int          RSTC   = 2;
    localparam int          LAT    = RSTC + SETTLE + 2;
    localparam logic [31:0] WORD   = 32'hA5C3_0F1E;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        i_tx_active;
    logic        i_tx_done;
    logic        o_trng_rst;
    logic        o_trng_en;
    logic [31:0] i_trng_data;
    logic        o_busy;
    logic [8:0]  o_words_left;

    // TX model state (written only by the model process)
    logic        tx_act  = 1'b0;
    logic        tx_dn   = 1'b0;
    int          tx_cnt  = 0;
    logic [7:0]  bytes_q[$];
    logic [8:0]  wl_q[$];
    int          viol    = 0;
    int          rst_falls = 0;
    logic        prev_rst = 1'b0;

    // Driven by the stimulus process
    logic        tx_hold = 1'b0;

    int          n_vec  = 0;
    int          n_fail = 0;

    assign i_trng_data = WORD;
    assign i_tx_active = tx_act | tx_hold;
    assign i_tx_done   = tx_dn;

    always #5 clk = ~clk;

    trng_burst_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .RST_CYCLES    (RSTC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_rx_dv      (i_rx_dv),
        .i_rx_byte    (i_rx_byte),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .i_tx_active  (i_tx_active),
        .i_tx_done    (i_tx_done),
        .o_trng_rst   (o_trng_rst),
        .o_trng_en    (o_trng_en),
        .i_trng_data  (i_trng_data),
        .o_busy       (o_busy),
        .o_words_left (o_words_left)
    );

    // UART TX model and monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        if (prev_rst === 1'b1 && o_trng_rst === 1'b0) rst_falls++;
        prev_rst = o_trng_rst;
        tx_dn = 1'b0;
        if (o_tx_dv === 1'b1) begin
            if (i_tx_active !== 1'b0) viol++;
            bytes_q.push_back(o_tx_byte);
            wl_q.push_back(o_words_left);
        end
        if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_act = 1'b0;
                tx_dn  = 1'b1;
            end
        end else if (o_tx_dv === 1'b1) begin
            tx_act = 1'b1;
            tx_cnt = 20;
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = WORD;
        return w[31 - 8*(i % 4) -: 8];
    endfunction

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(negedge clk);
        i_rx_dv   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (o_busy === 1'b0);
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (bytes_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (bytes_q.size() >= target);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (o_tx_dv !== 1'b0) begin n_fail++; $display("FAIL reset_tx_dv: got %b want 0", o_tx_dv); end
        n_vec++; if (o_tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", o_tx_byte); end
        n_vec++; if (o_trng_rst !== 1'b1) begin n_fail++; $display("FAIL reset_trng_rst: got %b want 1", o_trng_rst); end
        n_vec++; if (o_trng_en !== 1'b0) begin n_fail++; $display("FAIL reset_trng_en: got %b want 0", o_trng_en); end
        n_vec++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_vec++; if (o_words_left !== 9'd0) begin n_fail++; $display("FAIL reset_words_left: got %0d want 0", o_words_left); end
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int  base, cnt;
        bit  ok;
        base = bytes_q.size();
        send_rx(8'h52);
        n_vec++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", o_busy); end
        n_vec++; if (o_words_left !== 9'd1) begin n_fail++; $display("FAIL single_words_left: got %0d want 1", o_words_left); end
        n_vec++; if (o_trng_rst !== 1'b1) begin n_fail++; $display("FAIL single_arm_rst: got %b want 1", o_trng_rst); end
        cnt = 0;
        while (o_tx_dv !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++; if (cnt != LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", cnt, LAT); end
        n_vec++; if (o_trng_en !== 1'b1 || o_trng_rst !== 1'b0) begin
            n_fail++; $display("FAIL single_en_rst: got en=%b rst=%b want en=1 rst=0", o_trng_en, o_trng_rst); end
        wait_idle(500, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got busy=%b want 0", o_busy); end
        n_vec++; if (bytes_q.size() - base != 4) begin
            n_fail++; $display("FAIL single_count: got %0d want 4", bytes_q.size() - base); end
        else begin
            n_vec++; if ({bytes_q[base], bytes_q[base+1], bytes_q[base+2], bytes_q[base+3]} !== 32'hA5C30F1E) begin
                n_fail++; $display("FAIL single_bytes: got %h%h%h%h want a5c30f1e",
                                   bytes_q[base], bytes_q[base+1], bytes_q[base+2], bytes_q[base+3]); end
        end
        n_vec++; if (o_words_left !== 9'd0) begin n_fail++; $display("FAIL single_end_words: got %0d want 0", o_words_left); end
        n_vec++; if (o_trng_rst !== 1'b1 || o_trng_en !== 1'b0) begin
            n_fail++; $display("FAIL single_end_trng: got rst=%b en=%b want rst=1 en=0", o_trng_rst, o_trng_en); end
    endtask

    task automatic test_burst3();
        int  base, falls0, bad;
        bit  ok;
        base   = bytes_q.size();
        falls0 = rst_falls;
        send_rx(8'h42);
        send_rx(8'h03);
        n_vec++; if (o_words_left !== 9'd3) begin n_fail++; $display("FAIL burst3_start: got %0d want 3", o_words_left); end
        wait_idle(3000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL burst3_timeout: got busy=%b want 0", o_busy); end
        n_vec++; if (bytes_q.size() - base != 12) begin
            n_fail++; $display("FAIL burst3_count: got %0d want 12", bytes_q.size() - base); end
        else begin
            bad = 0;
            for (int i = 0; i < 12; i++) if (bytes_q[base+i] !== exp_byte(i)) bad++;
            n_vec++; if (bad != 0) begin n_fail++; $display("FAIL burst3_bytes: got %0d wrong want 0", bad); end
            n_vec++; if ({wl_q[base], wl_q[base+4], wl_q[base+8]} !== {9'd3, 9'd2, 9'd1}) begin
                n_fail++; $display("FAIL burst3_words_steps: got %0d,%0d,%0d want 3,2,1",
                                   wl_q[base], wl_q[base+4], wl_q[base+8]); end
        end
        n_vec++; if (rst_falls - falls0 != 1) begin
            n_fail++; $display("FAIL burst3_rst_pulses: got %0d want 1", rst_falls - falls0); end
        n_vec++; if (o_words_left !== 9'd0) begin n_fail++; $display("FAIL burst3_end_words: got %0d want 0", o_words_left); end
    endtask

    task automatic test_burst256();
        int  base, bad;
        bit  ok;
        base = bytes_q.size();
        send_rx(8'h42);
        send_rx(8'h00);
        n_vec++; if (o_words_left !== 9'd256) begin n_fail++; $display("FAIL burst256_start: got %0d want 256", o_words_left); end
        wait_idle(60000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL burst256_timeout: got busy=%b want 0", o_busy); end
        n_vec++; if (bytes_q.size() - base != 1024) begin
            n_fail++; $display("FAIL burst256_count: got %0d want 1024", bytes_q.size() - base); end
        else begin
            bad = 0;
            for (int i = 0; i < 1024; i++) if (bytes_q[base+i] !== exp_byte(i)) bad++;
            n_vec++; if (bad != 0) begin n_fail++; $display("FAIL burst256_bytes: got %0d wrong want 0", bad); end
            n_vec++; if (wl_q[base+1020] !== 9'd1) begin
                n_fail++; $display("FAIL burst256_last_words: got %0d want 1", wl_q[base+1020]); end
        end
    endtask

    task automatic test_stop();
        int  base;
        bit  ok;
        base = bytes_q.size();
        send_rx(8'h42);
        send_rx(8'h0A);
        wait_bytes(base + 5, 1000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL stop_reach_word2: got %0d bytes want 5", bytes_q.size() - base); end
        send_rx(8'h53);
        wait_idle(2000, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL stop_timeout: got busy=%b want 0", o_busy); end
        n_vec++; if (bytes_q.size() - base != 8) begin
            n_fail++; $display("FAIL stop_count: got %0d want 8", bytes_q.size() - base); end
        else begin
            n_vec++; if (bytes_q[base+7] !== 8'h1E) begin
                n_fail++; $display("FAIL stop_last_byte: got %h want 1e", bytes_q[base+7]); end
        end
    endtask

    task automatic test_hold();
        int  base;
        bit  ok;
        base = bytes_q.size();
        send_rx(8'h52);
        #2 tx_hold = 1'b1;
        repeat (LAT + 100) @(negedge clk);
        n_vec++; if (bytes_q.size() != base) begin
            n_fail++; $display("FAIL hold_no_dv: got %0d strobes want 0", bytes_q.size() - base); end
        #2 tx_hold = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bytes_q.size() - base != 1) begin
            n_fail++; $display("FAIL hold_one_dv: got %0d strobes want 1", bytes_q.size() - base); end
        wait_idle(500, ok);
        n_vec++; if (!ok || bytes_q.size() - base != 4) begin
            n_fail++; $display("FAIL hold_complete: got %0d bytes busy=%b want 4 busy=0", bytes_q.size() - base, o_busy); end
        n_vec++; if (viol != 0) begin n_fail++; $display("FAIL dv_while_active: got %0d want 0", viol); end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  ok;
        base = bytes_q.size();
        send_rx(8'h42);
        send_rx(8'h05);
        wait_bytes(base + 1, 500, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL rstmid_first_byte: got %0d bytes want 1", bytes_q.size() - base); end
        repeat (5) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        n_vec++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        n_vec++; if (o_trng_rst !== 1'b1) begin n_fail++; $display("FAIL rstmid_trng_rst: got %b want 1", o_trng_rst); end
        n_vec++; if (o_tx_dv !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_dv: got %b want 0", o_tx_dv); end
        n_vec++; if (o_words_left !== 9'd0) begin n_fail++; $display("FAIL rstmid_words: got %0d want 0", o_words_left); end
        repeat (30) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0 || bytes_q.size() - base != 1) begin
            n_fail++; $display("FAIL rstmid_stays_idle: got busy=%b bytes=%0d want busy=0 bytes=1", o_busy, bytes_q.size() - base); end
        base = bytes_q.size();
        send_rx(8'h52);
        wait_idle(500, ok);
        n_vec++; if (!ok || bytes_q.size() - base != 4) begin
            n_fail++; $display("FAIL rstmid_fresh_count: got %0d want 4", bytes_q.size() - base); end
        else begin
            n_vec++; if ({bytes_q[base], bytes_q[base+1], bytes_q[base+2], bytes_q[base+3]} !== 32'hA5C30F1E) begin
                n_fail++; $display("FAIL rstmid_fresh_word: got %h%h%h%h want a5c30f1e",
                                   bytes_q[base], bytes_q[base+1], bytes_q[base+2], bytes_q[base+3]); end
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        test_reset();
        test_single();
        test_burst3();
        test_burst256();
        test_stop();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
